histo_frame_sequencer: RTL and testbench

//  Sequences one histogram frame out through the byte-wise 32-bit word serializer (SPI-mode-0 output).
//  On frame_trig it sends a header word, then NUM_BINS bins read from the histogram RAM, then a checksum trailer.

---
 rtl/histo_pkg.sv | 18 +
 rtl/histo_frame_chk.sv | 15 +
 rtl/histo_prefetch.sv | 60 ++++++
 rtl/histo_frame_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_histo_frame_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/histo_pkg.sv
// Shared encodings and constants for the histogram frame sequencer.
// State codes stay plain 3-bit constants so legacy tooling can decode them.
package histo_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARM    = 3'd1;
   localparam logic [2:0] ST_PRIME  = 3'd2;
   localparam logic [2:0] ST_STREAM = 3'd3;
   localparam logic [2:0] ST_LAST   = 3'd4;

   localparam logic [15:0] HDR_MAGIC = 16'hA55A;

   // Word counter must hold NUM_BINS+1 with NUM_BINS up to 2**addr_w.
   function automatic int wcnt_width(input int addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/histo_frame_chk.sv
// Protocol checker: the serializer must never end a streaming word before
// the next word has been prefetched.
module histo_frame_chk (
   input logic clk,
   input logic rst_n,
   input logic in_stream,
   input logic ser_done,
   input logic nxt_v
);

   a_prefetch_ready: assert property (@(posedge clk) disable iff (!rst_n)
      (in_stream && ser_done) |-> nxt_v)
      else $error("histo_frame_chk: ser_done with empty prefetch");

endmodule

// File: rtl/histo_prefetch.sv
// One-word prefetch register plus running checksum of every captured bin.
// A captured bin or the final checksum waits here until the serializer asks for it.
module histo_prefetch
   import histo_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        cap,
   input  logic        consume,
   input  logic        load_trl,
   input  logic [31:0] rd_data,
   output logic [31:0] nxt,
   output logic        nxt_v,
   output logic [31:0] csum
);

   logic [31:0] nxt_q, nxt_d;
   logic [31:0] csum_q, csum_d;
   logic        nxt_v_q, nxt_v_d;

   // Loading the trailer outranks a consume on the same edge so it is never dropped.
   always_comb begin
      nxt_d   = nxt_q;
      nxt_v_d = nxt_v_q;
      csum_d  = csum_q;
      if (clr) begin
         csum_d  = 32'h0;
         nxt_v_d = 1'b0;
      end else if (cap) begin
         nxt_d   = rd_data;
         nxt_v_d = 1'b1;
         csum_d  = csum_q + rd_data;
      end else if (load_trl) begin
         nxt_d   = csum_q;
         nxt_v_d = 1'b1;
      end else if (consume) begin
         nxt_v_d = 1'b0;
      end else begin
         nxt_d = nxt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nxt_q   <= 32'h0;
         nxt_v_q <= 1'b0;
         csum_q  <= 32'h0;
      end else begin
         nxt_q   <= nxt_d;
         nxt_v_q <= nxt_v_d;
         csum_q  <= csum_d;
      end
   end

   assign nxt   = nxt_q;
   assign nxt_v = nxt_v_q;
   assign csum  = csum_q;

endmodule

// File: rtl/histo_frame_sequencer.sv
// Streams one histogram frame (header, NUM_BINS bins, checksum) into the
// byte-wise word serializer, optionally clearing each bin as it is read.
module histo_frame_sequencer
   import histo_pkg::*;
#(
   parameter int          NUM_BINS      = 1024,
   parameter int          ADDR_W        = 10,
   parameter logic [15:0] MAGIC         = HDR_MAGIC,
   parameter bit          CLEAR_ON_READ = 1'b1
) (
   input  logic              fast_clk_in,
   input  logic              reset_l,
   input  logic              frame_trig,
   input  logic              clr_err,
   output logic              hist_rd_en,
   output logic [ADDR_W-1:0] hist_rd_addr,
   input  logic [31:0]       hist_rd_data,
   output logic              hist_wr_en,
   output logic [ADDR_W-1:0] hist_wr_addr,
   output logic [31:0]       hist_wr_data,
   output logic              ser_reset,
   output logic [31:0]       ser_data,
   input  logic              ser_done,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun,
   output logic [15:0]       frame_cnt
);

   localparam int                WC_W       = wcnt_width(ADDR_W);
   localparam logic [WC_W-1:0]   WC_ALL     = WC_W'(NUM_BINS);
   localparam logic [WC_W-1:0]   WC_LASTBIN = WC_W'(NUM_BINS - 1);
   localparam logic [WC_W-1:0]   WC_ONE     = {{(WC_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] bin_idx_q, bin_idx_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              cap_q, cap_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              ser_reset_q, ser_reset_d;
   logic [31:0]       ser_data_q, ser_data_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              overrun_q, overrun_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;

   logic              pf_clr_s, pf_consume_s, pf_load_trl_s;
   logic [31:0]       nxt_s, csum_s;
   logic              nxt_v_s, in_stream_s;

   // Frame FSM; each serializer word boundary also schedules the next bin read.
   always_comb begin
      state_d       = state_q;
      bin_idx_d     = bin_idx_q;
      word_cnt_d    = word_cnt_q;
      rd_en_d       = 1'b0;
      rd_addr_d     = rd_addr_q;
      ser_reset_d   = ser_reset_q;
      ser_data_d    = ser_data_q;
      busy_d        = busy_q;
      frame_done_d  = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      pf_clr_s      = 1'b0;
      pf_consume_s  = 1'b0;
      pf_load_trl_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ser_reset_d = 1'b1;
            if (frame_trig) begin
               ser_data_d = {MAGIC, frame_cnt_q};
               rd_en_d    = 1'b1;
               rd_addr_d  = {ADDR_W{1'b0}};
               bin_idx_d  = {ADDR_W{1'b0}};
               word_cnt_d = {WC_W{1'b0}};
               pf_clr_s   = 1'b1;
               busy_d     = 1'b1;
               state_d    = ST_ARM;
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_ARM: begin
            ser_reset_d = 1'b0;
            state_d     = ST_PRIME;
         end
         ST_PRIME: begin
            if (ser_done) begin
               state_d = ST_STREAM;
            end else begin
               state_d = ST_PRIME;
            end
         end
         ST_STREAM: begin
            if (ser_done) begin
               ser_data_d   = nxt_s;
               pf_consume_s = 1'b1;
               word_cnt_d   = word_cnt_q + WC_ONE;
               if (word_cnt_q == WC_ALL) begin
                  state_d = ST_LAST;
               end else if (word_cnt_q == WC_LASTBIN) begin
                  pf_load_trl_s = 1'b1;
               end else begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = bin_idx_q + ADDR_ONE;
                  bin_idx_d = bin_idx_q + ADDR_ONE;
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_LAST: begin
            if (ser_done) begin
               ser_reset_d  = 1'b1;
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               busy_d       = 1'b0;
               state_d      = ST_IDLE;
            end else begin
               state_d = ST_LAST;
            end
         end
         default: begin
            ser_reset_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Read data arrives the cycle after the strobe; the clear follows the capture.
   always_comb begin
      cap_d     = rd_en_q;
      wr_en_d   = CLEAR_ON_READ && cap_q;
      wr_addr_d = cap_q ? rd_addr_q : wr_addr_q;
      if (frame_trig && busy_q) begin
         overrun_d = 1'b1;
      end else if (clr_err) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge fast_clk_in or negedge reset_l) begin
      if (!reset_l) begin
         state_q      <= ST_IDLE;
         bin_idx_q    <= {ADDR_W{1'b0}};
         word_cnt_q   <= {WC_W{1'b0}};
         rd_en_q      <= 1'b0;
         rd_addr_q    <= {ADDR_W{1'b0}};
         cap_q        <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= {ADDR_W{1'b0}};
         ser_reset_q  <= 1'b1;
         ser_data_q   <= 32'h0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_cnt_q  <= 16'h0;
      end else begin
         state_q      <= state_d;
         bin_idx_q    <= bin_idx_d;
         word_cnt_q   <= word_cnt_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         cap_q        <= cap_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         ser_reset_q  <= ser_reset_d;
         ser_data_q   <= ser_data_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   histo_prefetch u_prefetch (
      .clk      (fast_clk_in),
      .rst_n    (reset_l),
      .clr      (pf_clr_s),
      .cap      (cap_q),
      .consume  (pf_consume_s),
      .load_trl (pf_load_trl_s),
      .rd_data  (hist_rd_data),
      .nxt      (nxt_s),
      .nxt_v    (nxt_v_s),
      .csum     (csum_s)
   );

   assign in_stream_s = (state_q == ST_STREAM);

   histo_frame_chk u_chk (
      .clk       (fast_clk_in),
      .rst_n     (reset_l),
      .in_stream (in_stream_s),
      .ser_done  (ser_done),
      .nxt_v     (nxt_v_s)
   );

   assign hist_rd_en   = rd_en_q;
   assign hist_rd_addr = rd_addr_q;
   assign hist_wr_en   = wr_en_q;
   assign hist_wr_addr = wr_addr_q;
   assign hist_wr_data = 32'h0;
   assign ser_reset    = ser_reset_q;
   assign ser_data     = ser_data_q;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
   assign overrun      = overrun_q;
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_histo_frame_sequencer.sv
// Directed bench: 4-bin RAM model with 1-cycle read latency and a serializer
// model that gives a priming done, then a done every 256 cycles.
module tb_histo_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_trig;
   logic        clr_err;
   logic        hist_rd_en;
   logic [9:0]  hist_rd_addr;
   logic [31:0] hist_rd_data;
   logic        hist_wr_en;
   logic [9:0]  hist_wr_addr;
   logic [31:0] hist_wr_data;
   logic        ser_reset;
   logic [31:0] ser_data;
   logic        ser_done = 1'b0;
   logic        busy;
   logic        frame_done;
   logic        overrun;
   logic [15:0] frame_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   histo_frame_sequencer #(
      .NUM_BINS      (4),
      .ADDR_W        (10),
      .MAGIC         (16'hA55A),
      .CLEAR_ON_READ (1'b1)
   ) dut (
      .fast_clk_in  (clk),
      .reset_l      (rst_n),
      .frame_trig   (frame_trig),
      .clr_err      (clr_err),
      .hist_rd_en   (hist_rd_en),
      .hist_rd_addr (hist_rd_addr),
      .hist_rd_data (hist_rd_data),
      .hist_wr_en   (hist_wr_en),
      .hist_wr_addr (hist_wr_addr),
      .hist_wr_data (hist_wr_data),
      .ser_reset    (ser_reset),
      .ser_data     (ser_data),
      .ser_done     (ser_done),
      .busy         (busy),
      .frame_done   (frame_done),
      .overrun      (overrun),
      .frame_cnt    (frame_cnt)
   );

   // RAM model with a bench load port
   logic [31:0] mem [0:3];
   logic        ld_en;
   logic [1:0]  ld_addr;
   logic [31:0] ld_data;

   always @(posedge clk) begin
      if (hist_rd_en) hist_rd_data <= mem[hist_rd_addr[1:0]];
      if (hist_wr_en) mem[hist_wr_addr[1:0]] <= hist_wr_data;
      if (ld_en) mem[ld_addr] <= ld_data;
   end

   // Serializer model
   logic [8:0] sm_cnt;
   logic       sm_primed;
   logic       sm_prime_pulse;

   always @(posedge clk) begin
      if (ser_reset) begin
         sm_cnt         <= 9'd0;
         sm_primed      <= 1'b0;
         ser_done       <= 1'b0;
         sm_prime_pulse <= 1'b0;
      end else begin
         ser_done       <= 1'b0;
         sm_prime_pulse <= 1'b0;
         if (!sm_primed) begin
            if (sm_cnt == 9'd3) begin
               ser_done       <= 1'b1;
               sm_prime_pulse <= 1'b1;
               sm_primed      <= 1'b1;
               sm_cnt         <= 9'd0;
            end else begin
               sm_cnt <= sm_cnt + 9'd1;
            end
         end else if (sm_cnt == 9'd255) begin
            ser_done <= 1'b1;
            sm_cnt   <= 9'd0;
         end else begin
            sm_cnt <= sm_cnt + 9'd1;
         end
      end
   end

   // Word recorder: the word that ends on each non-priming done
   logic [31:0] words [0:15];
   logic [4:0]  nwords;
   logic        rec_clr;

   always @(posedge clk) begin
      if (rec_clr) begin
         nwords <= 5'd0;
      end else if (ser_done && !sm_prime_pulse && nwords < 5'd16) begin
         words[nwords[3:0]] <= ser_data;
         nwords <= nwords + 5'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_bins(input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3);
      logic [31:0] v [0:3];
      v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ld_en = 1'b1; ld_addr = 2'(i); ld_data = v[i];
      end
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic start_frame();
      @(negedge clk);
      rec_clr = 1'b1;
      @(negedge clk);
      rec_clr    = 1'b0;
      frame_trig = 1'b1;
      @(negedge clk);
      frame_trig = 1'b0;
   endtask

   task automatic wait_words(input string tag, input int n);
      logic ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (int'(nwords) >= n) ok = 1'b1;
      end
      chk({tag, "_words_reached"}, {31'h0, ok}, 32'h1);
   endtask

   task automatic check_frame(input string tag, input logic [31:0] hdr,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [31:0] b3,
                              input logic [31:0] trl, input logic [15:0] fc);
      logic [31:0] e [0:5];
      logic ok = 1'b0;
      e[0] = hdr; e[1] = b0; e[2] = b1; e[3] = b2; e[4] = b3; e[5] = trl;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) ok = 1'b1;
      end
      chk({tag, "_frame_done"}, {31'h0, ok}, 32'h1);
      chk({tag, "_nwords"}, {27'h0, nwords}, 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("%s_word%0d", tag, i), words[i], e[i]);
      end
      chk({tag, "_frame_cnt"}, {16'h0, frame_cnt}, {16'h0, fc});
      chk({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
      chk({tag, "_ser_reset_end"}, {31'h0, ser_reset}, 32'h1);
      @(negedge clk);
      chk({tag, "_done_pulse_1cyc"}, {31'h0, frame_done}, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; frame_trig = 1'b0; clr_err = 1'b0;
      ld_en = 1'b0; ld_addr = 2'd0; ld_data = 32'h0; rec_clr = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ser_reset", {31'h0, ser_reset}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
      chk("rst_overrun", {31'h0, overrun}, 32'h0);
      chk("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
      chk("rst_ser_data", ser_data, 32'h0);
      chk("rst_rd_wr_en", {30'h0, hist_rd_en, hist_wr_en}, 32'h0);
      rst_n = 1'b1;

      // 1: basic frame
      load_bins(32'd1, 32'd2, 32'd3, 32'd4);
      start_frame();
      chk("t1_busy", {31'h0, busy}, 32'h1);
      check_frame("t1", 32'hA55A0000, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A, 16'h0001);

      // 2: bins cleared by previous read
      for (int i = 0; i < 4; i++) chk($sformatf("t2_mem%0d", i), mem[i], 32'h0);
      start_frame();
      check_frame("t2", 32'hA55A0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0002);

      // 3: checksum wraps
      load_bins(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      start_frame();
      check_frame("t3", 32'hA55A0002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFF, 32'hFFFFFFFC, 16'h0003);

      // 4: trigger while busy sets overrun; a set beats a simultaneous clear
      load_bins(32'd10, 32'd20, 32'd30, 32'd40);
      start_frame();
      wait_words("t4", 2);
      frame_trig = 1'b1;
      @(negedge clk);
      frame_trig = 1'b0;
      chk("t4_overrun_set", {31'h0, overrun}, 32'h1);
      chk("t4_still_busy", {31'h0, busy}, 32'h1);
      frame_trig = 1'b1; clr_err = 1'b1;
      @(negedge clk);
      frame_trig = 1'b0; clr_err = 1'b0;
      chk("t4_set_wins", {31'h0, overrun}, 32'h1);
      check_frame("t4", 32'hA55A0003, 32'd10, 32'd20, 32'd30, 32'd40, 32'h00000064, 16'h0004);
      repeat (5) @(negedge clk);
      chk("t4_no_restart", {31'h0, busy}, 32'h0);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("t4_overrun_clr", {31'h0, overrun}, 32'h0);

      // 5: asynchronous reset mid-frame
      load_bins(32'd5, 32'd6, 32'd7, 32'd8);
      start_frame();
      wait_words("t5", 2);
      rst_n = 1'b0;
      #1;
      chk("t5_ser_reset", {31'h0, ser_reset}, 32'h1);
      chk("t5_busy", {31'h0, busy}, 32'h0);
      chk("t5_frame_cnt", {16'h0, frame_cnt}, 32'h0);
      chk("t5_wr_en", {31'h0, hist_wr_en}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      load_bins(32'd5, 32'd6, 32'd7, 32'd8);
      start_frame();
      check_frame("t5", 32'hA55A0000, 32'd5, 32'd6, 32'd7, 32'd8, 32'h0000001A, 16'h0001);

      // 6: frame counter at FFFF wraps after the frame
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt_q;
      @(negedge clk);
      chk("t6_preset", {16'h0, frame_cnt}, 32'h0000FFFF);
      load_bins(32'd1, 32'd1, 32'd1, 32'd1);
      start_frame();
      check_frame("t6", 32'hA55AFFFF, 32'd1, 32'd1, 32'd1, 32'd1, 32'h00000004, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
